// File: rtl/obstacle_control_pkg.sv
// Shared types and select codes for the bouncing-ball obstacle controller.
package obstacle_control_pkg;

    // Controller states; 4-bit encoding leaves room for growth.
    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_DRAW    = 4'd1,
        S_WAIT    = 4'd2,
        S_ERASE   = 4'd3,
        S_PROBE_Y = 4'd4,
        S_TEST_Y  = 4'd5,
        S_PROBE_X = 4'd6,
        S_TEST_X  = 4'd7,
        S_MOVE    = 4'd8
    } state_e;

    // Obstacle probe select: which neighbour pixel the datapath addresses.
    localparam logic [1:0] PROBE_UP    = 2'd0;
    localparam logic [1:0] PROBE_DOWN  = 2'd1;
    localparam logic [1:0] PROBE_LEFT  = 2'd2;
    localparam logic [1:0] PROBE_RIGHT = 2'd3;

    // Position register select.
    localparam logic [1:0] POS_LOAD = 2'd0;
    localparam logic [1:0] POS_DEC  = 2'd1;
    localparam logic [1:0] POS_INC  = 2'd2;

    // Direction register select.
    localparam logic DIR_LOAD   = 1'b0;
    localparam logic DIR_TOGGLE = 1'b1;

    // Timer select.
    localparam logic TMR_CLR = 1'b0;
    localparam logic TMR_INC = 1'b1;

    // Plot colour.
    localparam logic COLOR_BLACK = 1'b0;
    localparam logic COLOR_GREEN = 1'b1;

    // Probe the pixel ahead of travel on the chosen axis.
    function automatic logic [1:0] probe_sel(input logic y_axis, input logic dir);
        if (y_axis) begin
            return dir ? PROBE_DOWN : PROBE_UP;
        end
        return dir ? PROBE_RIGHT : PROBE_LEFT;
    endfunction

    // Step a position register one pixel in the travel direction.
    function automatic logic [1:0] step_sel(input logic dir);
        return dir ? POS_INC : POS_DEC;
    endfunction

endpackage

// File: rtl/obstacle_control_if.sv
// Controller <-> datapath bundle for the bouncing-ball obstacle game.
//
// Signalling: there is no valid/ready back-pressure on this bundle. Every
// en_* and its s_* select are sampled by the datapath on the next rising
// edge. plot is a one-cycle write strobe that the VGA side must accept in
// the cycle it is high, using the current xpos/ypos and s_color. obstacle
// is valid OBS_LAT cycles after s_obs_xy and the position have settled.
interface obstacle_control_if #(
    parameter int CNT_W = 16
);
    // datapath -> controller
    logic             xdir;
    logic             ydir;
    logic             timer_done;
    logic             obstacle;
    // controller -> datapath / VGA
    logic             en_xpos;
    logic             en_ypos;
    logic             en_xdir;
    logic             en_ydir;
    logic             en_timer;
    logic [1:0]       s_xpos;
    logic [1:0]       s_ypos;
    logic             s_xdir;
    logic             s_ydir;
    logic             s_timer;
    logic             s_color;
    logic [1:0]       s_obs_xy;
    logic             plot;
    logic [CNT_W-1:0] bounces;

    modport master (
        input  xdir, ydir, timer_done, obstacle,
        output en_xpos, en_ypos, en_xdir, en_ydir, en_timer,
        output s_xpos, s_ypos, s_xdir, s_ydir, s_timer, s_color, s_obs_xy,
        output plot, bounces
    );

    modport slave (
        output xdir, ydir, timer_done, obstacle,
        input  en_xpos, en_ypos, en_xdir, en_ydir, en_timer,
        input  s_xpos, s_ypos, s_xdir, s_ydir, s_timer, s_color, s_obs_xy,
        input  plot, bounces
    );
endinterface

// File: rtl/obstacle_control.sv
// Moore controller for the bouncing-ball datapath: draw, wait on the pace
// timer, erase, probe the obstacle RAM ahead of travel on each axis,
// reflect on a hit, then step the ball diagonally.
module obstacle_control
    import obstacle_control_pkg::*;
#(
    parameter int OBS_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    obstacle_control_if.master bus,
    output state_e             dbg_state_o
);

    localparam int               LAT_W    = (OBS_LAT > 1) ? $clog2(OBS_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(OBS_LAT - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] bounces_q, bounces_d;
    logic             hit;

    logic             en_xpos, en_ypos, en_xdir, en_ydir, en_timer;
    logic [1:0]       s_xpos, s_ypos, s_obs_xy;
    logic             s_xdir, s_ydir, s_timer, s_color, plot;

    // State, probe-latency and bounce registers; reset lands in S_INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            lat_q     <= '0;
            bounces_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            bounces_q <= bounces_d;
        end
    end

    // Next-state sequencing; probe states dwell OBS_LAT cycles for the RAM read.
    always_comb begin
        state_d = state_q;
        lat_d   = '0;
        case (state_q)
            S_INIT:  state_d = S_DRAW;
            S_DRAW:  state_d = S_WAIT;
            // timer_done wins even when run is low.
            S_WAIT:  if (bus.timer_done) state_d = S_ERASE;
            S_ERASE: state_d = S_PROBE_Y;
            S_PROBE_Y: begin
                if (lat_q == LAT_LAST) state_d = S_TEST_Y;
                else                   lat_d   = lat_q + LAT_W'(1);
            end
            S_TEST_Y: state_d = S_PROBE_X;
            S_PROBE_X: begin
                if (lat_q == LAT_LAST) state_d = S_TEST_X;
                else                   lat_d   = lat_q + LAT_W'(1);
            end
            S_TEST_X: state_d = S_MOVE;
            S_MOVE:   state_d = S_DRAW;
            default:  state_d = S_INIT;
        endcase
    end

    // Count every reflection; wraps silently at the counter width.
    always_comb begin
        hit       = ((state_q == S_TEST_Y) || (state_q == S_TEST_X)) && bus.obstacle;
        bounces_d = hit ? bounces_q + CNT_W'(1) : bounces_q;
    end

    // Output decode from state; only the dir enables in TEST states follow obstacle.
    always_comb begin
        en_xpos  = 1'b0;
        en_ypos  = 1'b0;
        en_xdir  = 1'b0;
        en_ydir  = 1'b0;
        en_timer = 1'b0;
        s_xpos   = POS_LOAD;
        s_ypos   = POS_LOAD;
        s_xdir   = DIR_LOAD;
        s_ydir   = DIR_LOAD;
        s_timer  = TMR_CLR;
        s_color  = COLOR_BLACK;
        s_obs_xy = PROBE_UP;
        plot     = 1'b0;
        case (state_q)
            S_INIT: begin
                // Selects stay at their load/clear defaults.
                en_xpos  = 1'b1;
                en_ypos  = 1'b1;
                en_xdir  = 1'b1;
                en_ydir  = 1'b1;
                en_timer = 1'b1;
            end
            S_DRAW: begin
                s_color = COLOR_GREEN;
                plot    = 1'b1;
            end
            S_WAIT: begin
                s_timer  = TMR_INC;
                en_timer = run;
            end
            S_ERASE: begin
                s_color  = COLOR_BLACK;
                plot     = 1'b1;
                en_timer = 1'b1;
                s_timer  = TMR_CLR;
            end
            S_PROBE_Y: s_obs_xy = probe_sel(1'b1, bus.ydir);
            S_TEST_Y: begin
                s_obs_xy = probe_sel(1'b1, bus.ydir);
                s_ydir   = DIR_TOGGLE;
                en_ydir  = bus.obstacle;
            end
            S_PROBE_X: s_obs_xy = probe_sel(1'b0, bus.xdir);
            S_TEST_X: begin
                s_obs_xy = probe_sel(1'b0, bus.xdir);
                s_xdir   = DIR_TOGGLE;
                en_xdir  = bus.obstacle;
            end
            S_MOVE: begin
                // Directions have already absorbed any reflection.
                en_xpos = 1'b1;
                en_ypos = 1'b1;
                s_xpos  = step_sel(bus.xdir);
                s_ypos  = step_sel(bus.ydir);
            end
            default: ;
        endcase
    end

    assign bus.en_xpos  = en_xpos;
    assign bus.en_ypos  = en_ypos;
    assign bus.en_xdir  = en_xdir;
    assign bus.en_ydir  = en_ydir;
    assign bus.en_timer = en_timer;
    assign bus.s_xpos   = s_xpos;
    assign bus.s_ypos   = s_ypos;
    assign bus.s_xdir   = s_xdir;
    assign bus.s_ydir   = s_ydir;
    assign bus.s_timer  = s_timer;
    assign bus.s_color  = s_color;
    assign bus.s_obs_xy = s_obs_xy;
    assign bus.plot     = plot;
    assign bus.bounces  = bounces_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_obstacle_control.sv
// Bench for obstacle_control: behavioural datapath + obstacle RAM around the
// DUT, and a frame-level ball model feeding an expected plot queue.
// Bounce counter is narrowed to 8 bits so wrap-around is reachable quickly.
module tb_obstacle_control;
    import obstacle_control_pkg::*;

    localparam int CNT_W       = 8;
    localparam int OBS_LAT     = 1;
    localparam int TIMER_LIMIT = 4;
    localparam int X_MAX       = 160;
    localparam int Y_MAX       = 120;
    localparam int W           = 24;
    // draw + wait(timer 0..LIMIT) + erase..move
    localparam int PERIOD      = 1 + (TIMER_LIMIT + 1) + 2 * (OBS_LAT + 1) + 2;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    logic   run   = 1'b0;
    state_e dbg_state;

    always #5 clk = ~clk;

    obstacle_control_if #(.CNT_W(CNT_W)) bus ();

    obstacle_control #(.OBS_LAT(OBS_LAT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- datapath + RAM model ----------------
    bit   obs_map [0:X_MAX-1][0:Y_MAX-1];
    int   dp_x, dp_y, dp_timer;
    logic dp_xdir, dp_ydir, dp_obs;

    assign bus.xdir       = dp_xdir;
    assign bus.ydir       = dp_ydir;
    assign bus.timer_done = (dp_timer == TIMER_LIMIT);
    assign bus.obstacle   = dp_obs;

    function automatic bit map_at(int x, int y);
        if (x < 0 || x >= X_MAX || y < 0 || y >= Y_MAX) return 1'b1;
        return obs_map[x][y];
    endfunction

    function automatic int pos_next(int p, logic [1:0] sel, int start);
        case (sel)
            2'd0:    return start;
            2'd1:    return p - 1;
            2'd2:    return p + 1;
            default: return p;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_x <= 80; dp_y <= 60; dp_xdir <= 1'b1; dp_ydir <= 1'b1;
            dp_timer <= 0; dp_obs <= 1'b0;
        end else begin
            if (bus.en_xpos)  dp_x     <= pos_next(dp_x, bus.s_xpos, 80);
            if (bus.en_ypos)  dp_y     <= pos_next(dp_y, bus.s_ypos, 60);
            if (bus.en_xdir)  dp_xdir  <= bus.s_xdir ? ~dp_xdir : 1'b1;
            if (bus.en_ydir)  dp_ydir  <= bus.s_ydir ? ~dp_ydir : 1'b1;
            if (bus.en_timer) dp_timer <= bus.s_timer ? dp_timer + 1 : 0;
            case (bus.s_obs_xy)
                2'd0:    dp_obs <= map_at(dp_x, dp_y - 1);
                2'd1:    dp_obs <= map_at(dp_x, dp_y + 1);
                2'd2:    dp_obs <= map_at(dp_x - 1, dp_y);
                default: dp_obs <= map_at(dp_x + 1, dp_y);
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [W-1:0]   exp_q[$];
    int             m_x, m_y, m_bounces;
    bit             m_xdir, m_ydir;
    int             cyc, last_draw_cyc, draw_count, last_x, last_y;
    bit             have_last, run_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_plot(int x, int y, bit color);
        return {8'(x), 8'(y), 8'(color)};
    endfunction

    function automatic void push_frame();
        exp_q.push_back(pack_plot(m_x, m_y, 1'b1));
        exp_q.push_back(pack_plot(m_x, m_y, 1'b0));
    endfunction

    // One frame of ball physics: test y then x neighbour, reflect, step.
    function automatic void model_step();
        int dx, dy;
        dy = m_ydir ? 1 : -1;
        if (map_at(m_x, m_y + dy)) begin m_ydir = !m_ydir; m_bounces++; end
        dx = m_xdir ? 1 : -1;
        if (map_at(m_x + dx, m_y)) begin m_xdir = !m_xdir; m_bounces++; end
        m_x += m_xdir ? 1 : -1;
        m_y += m_ydir ? 1 : -1;
    endfunction

    function automatic void model_init();
        m_x = 80; m_y = 60; m_xdir = 1'b1; m_ydir = 1'b1; m_bounces = 0;
        exp_q.delete();
        push_frame();
        draw_count = 0; have_last = 1'b0; run_low = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (!run) run_low = 1'b1;
            if (bus.plot) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("plot_xyc", pack_plot(dp_x, dp_y, bus.s_color), exp_q.pop_front());
                if (bus.s_color) begin
                    check("bounces", 32'(bus.bounces), 32'(m_bounces[CNT_W-1:0]));
                    if (have_last && !run_low) check("period", cyc - last_draw_cyc, PERIOD);
                    have_last = 1'b1; run_low = 1'b0;
                    last_draw_cyc = cyc; last_x = dp_x; last_y = dp_y;
                    draw_count++;
                end else begin
                    model_step();
                    push_frame();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup_map(input int kind);
        for (int x = 0; x < X_MAX; x++)
            for (int y = 0; y < Y_MAX; y++)
                obs_map[x][y] = (x == 0 || y == 0 || x == X_MAX - 1 || y == Y_MAX - 1);
        case (kind)
            1: obs_map[80][61] = 1'b1;
            2: begin obs_map[80][61] = 1'b1; obs_map[81][60] = 1'b1; end
            3: for (int x = 1; x < X_MAX - 1; x++)
                   for (int y = 1; y < Y_MAX - 1; y++)
                       obs_map[x][y] = ($urandom_range(0, 11) == 0);
            4: for (int x = 78; x <= 82; x++)
                   for (int y = 58; y <= 62; y++)
                       if (x == 78 || x == 82 || y == 58 || y == 62) obs_map[x][y] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic do_reset(input bit chk, input string tag);
        reset = 1'b1;
        #1;
        if (chk) begin
            check({tag, "_state"},  32'(dbg_state), 32'(S_INIT));
            check({tag, "_plot"},   32'(bus.plot), 32'd0);
            check({tag, "_en_xpos"}, 32'(bus.en_xpos), 32'd1);
            check({tag, "_s_xpos"}, 32'(bus.s_xpos), 32'd0);
            check({tag, "_bounces"}, 32'(bus.bounces), 32'd0);
        end
        model_init();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_draws(input int n);
        for (int i = 0; i < n * PERIOD * 3 + 100; i++) begin
            @(negedge clk); #1;
            if (draw_count >= n) return;
        end
        check("timeout_draws", 32'(draw_count), 32'(n));
    endtask

    task automatic wait_state(input state_e s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dbg_state == s) return;
        end
        check("timeout_state", 32'(dbg_state), 32'(s));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int plots, ents, n;
        run = 1'b1;

        // Power-up reset and free field.
        setup_map(0);
        do_reset(1'b1, "por");
        wait_draws(2);
        check("free_pos", pack_plot(last_x, last_y, 1'b1), pack_plot(81, 61, 1'b1));
        check("free_bounces", 32'(bus.bounces), 32'd0);
        wait_draws(5);

        // Reset asserted in the middle of S_WAIT.
        wait_state(S_WAIT);
        do_reset(1'b1, "midwait");

        // Obstacle directly below the start position.
        setup_map(1);
        do_reset(1'b0, "");
        wait_draws(2);
        check("below_pos", pack_plot(last_x, last_y, 1'b1), pack_plot(81, 59, 1'b1));
        check("below_bounces", 32'(bus.bounces), 32'd1);

        // Corner: below and right both blocked.
        setup_map(2);
        do_reset(1'b0, "");
        wait_draws(2);
        check("corner_pos", pack_plot(last_x, last_y, 1'b1), pack_plot(79, 59, 1'b1));
        check("corner_bounces", 32'(bus.bounces), 32'd2);

        // Freeze in S_WAIT with run low, then resume.
        setup_map(0);
        do_reset(1'b0, "");
        wait_state(S_WAIT);
        run = 1'b0;
        plots = 0; ents = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.plot) plots++;
            if (bus.en_timer) ents++;
        end
        check("freeze_plot", 32'(plots), 32'd0);
        check("freeze_en_timer", 32'(ents), 32'd0);
        check("freeze_state", 32'(dbg_state), 32'(S_WAIT));
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.plot && n < 50);
        check("resume_latency", 32'(n), 32'(TIMER_LIMIT + 1));
        check("resume_color", 32'(bus.s_color), 32'd0);

        // Random obstacle field with random run gating.
        setup_map(3);
        do_reset(1'b0, "");
        repeat (3000) begin
            @(negedge clk);
            run = ($urandom_range(0, 7) != 0);
        end
        run = 1'b1;
        n = draw_count;
        wait_draws(n + 3);

        // Caged ball: steady bounces drive the counter through wrap-around.
        setup_map(4);
        do_reset(1'b0, "");
        wait_draws(300);
        check("cage_pos", pack_plot(last_x, last_y, 1'b1), pack_plot(79, 59, 1'b1));
        check("cage_wrap", 32'(bus.bounces), 32'(298 % 256));

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
